// File: rtl/mul_ctrl_if.sv
// Bundles the execute-stage M-op handshake with the iterative multiplier link.
// The slave modport is the controller; master is the pipeline plus multiplier.
interface mul_ctrl_if;
  logic        req;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        stall;
  logic        resp;
  logic [31:0] rd_data;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_product;
  logic        mul_resp;

  modport slave (
    input  req, funct3, rs1, rs2, mul_product, mul_resp,
    output stall, resp, rd_data, mul_start, mul_a, mul_b
  );

  modport master (
    output req, funct3, rs1, rs2, mul_product, mul_resp,
    input  stall, resp, rd_data, mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/mul_ctrl.sv
// RV32 M-extension multiply sequencer: sign handling around an unsigned
// iterative multiplier, with a single-entry last-product reuse cache.
module mul_ctrl #(
  parameter int unsigned CACHE_EN = 1
) (
  input  logic      clk,
  input  logic      rst,
  mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIX,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mag_a_q, mag_b_q;
  logic        neg_q, hi_q;
  logic [63:0] prod_q;
  logic [31:0] res_q;
  logic        cvld_q;
  logic [31:0] ctag_a_q, ctag_b_q;
  logic [63:0] cprod_q;

  logic        accept;
  logic        sgn_a, sgn_b;
  logic [31:0] mag_a_c, mag_b_c;
  logic        neg_c;
  logic        hit_c;
  logic [63:0] prod_fix;

  assign accept  = bus.req & ~bus.funct3[2];
  assign sgn_a   = (bus.funct3[1:0] == 2'b01) | (bus.funct3[1:0] == 2'b10);
  assign sgn_b   = (bus.funct3[1:0] == 2'b01);
  assign mag_a_c = (sgn_a & bus.rs1[31]) ? (~bus.rs1 + 32'd1) : bus.rs1;
  assign mag_b_c = (sgn_b & bus.rs2[31]) ? (~bus.rs2 + 32'd1) : bus.rs2;
  assign neg_c   = (sgn_a & bus.rs1[31]) ^ (sgn_b & bus.rs2[31]);

  // Tags hold magnitudes, so a hit is valid across any signedness mix.
  assign hit_c = (CACHE_EN != 0) && cvld_q &&
                 (mag_a_c == ctag_a_q) && (mag_b_c == ctag_b_q);

  assign prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.stall     = 1'b0;
    bus.resp      = 1'b0;
    bus.rd_data   = '0;
    bus.mul_start = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = hit_c ? FIX : ISSUE;
      ISSUE: begin
        bus.mul_start = 1'b1;
        state_d       = WAIT;
      end
      WAIT:    if (bus.mul_resp) state_d = FIX;
      FIX:     state_d = RESP;
      RESP: begin
        bus.resp    = 1'b1;
        bus.rd_data = res_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Gated by rst so the hold drops the moment reset asserts.
    bus.stall = rst & accept & (state_q != RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      prod_q   <= '0;
      res_q    <= '0;
      cvld_q   <= 1'b0;
      ctag_a_q <= '0;
      ctag_b_q <= '0;
      cprod_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mag_a_q <= mag_a_c;
          mag_b_q <= mag_b_c;
          neg_q   <= neg_c;
          hi_q    <= (bus.funct3[1:0] != 2'b00);
          if (hit_c) prod_q <= cprod_q;
        end
        WAIT: if (bus.mul_resp) begin
          prod_q   <= bus.mul_product;
          cvld_q   <= 1'b1;
          ctag_a_q <= mag_a_q;
          ctag_b_q <= mag_b_q;
          cprod_q  <= bus.mul_product;
        end
        FIX:  res_q <= hi_q ? prod_fix[63:32] : prod_fix[31:0];
        default: ;
      endcase
    end
  end

  assign bus.mul_a = mag_a_q;
  assign bus.mul_b = mag_b_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed self-checking bench for mul_ctrl; the bench plays both the
// pipeline and the iterative multiplier with hand-computed products.
module tb_mul_ctrl;

  logic clk;
  logic rst;
  mul_ctrl_if bus ();

  mul_ctrl #(.CACHE_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned starts     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mul_start === 1'b1) starts <= starts + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one M-op through accept..resp with fixed-cycle expectations.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hit, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [63:0] prod, input int unsigned wait_cyc,
                        input logic [31:0] erd, input string name);
    int unsigned s0;
    @(negedge clk);
    s0 = starts;
    bus.req = 1'b1; bus.funct3 = f3; bus.rs1 = a; bus.rs2 = b;
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL %s accept_stall: got %b want 1", name, bus.stall);
    end
    @(negedge clk);
    vectors++;
    if (bus.mul_start !== !hit) begin
      miscompares++; $display("FAIL %s mul_start: got %b want %b", name, bus.mul_start, !hit);
    end
    vectors++;
    if (bus.mul_a !== ea || bus.mul_b !== eb) begin
      miscompares++;
      $display("FAIL %s operands: got a=%h b=%h want a=%h b=%h", name, bus.mul_a, bus.mul_b, ea, eb);
    end
    if (!hit) begin
      for (int i = 0; i < int'(wait_cyc); i++) begin
        @(negedge clk);
        vectors++;
        if (bus.mul_start !== 1'b0 || bus.stall !== 1'b1 || bus.resp !== 1'b0) begin
          miscompares++;
          $display("FAIL %s wait%0d: got start=%b stall=%b resp=%b want 0 1 0",
                   name, i, bus.mul_start, bus.stall, bus.resp);
        end
      end
      bus.mul_resp = 1'b1; bus.mul_product = prod;
      @(negedge clk);
      bus.mul_resp = 1'b0; bus.mul_product = '0;
      vectors++;
      if (bus.resp !== 1'b0 || bus.stall !== 1'b1) begin
        miscompares++; $display("FAIL %s fix: got resp=%b stall=%b want 0 1", name, bus.resp, bus.stall);
      end
    end else begin
      vectors++;
      if (bus.resp !== 1'b0 || bus.stall !== 1'b1) begin
        miscompares++; $display("FAIL %s hit_fix: got resp=%b stall=%b want 0 1", name, bus.resp, bus.stall);
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.resp !== 1'b1 || bus.rd_data !== erd || bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL %s result: got resp=%b rd=%h stall=%b want 1 %h 0",
               name, bus.resp, bus.rd_data, bus.stall, erd);
    end
    vectors++;
    if (starts !== s0 + (hit ? 0 : 1)) begin
      miscompares++; $display("FAIL %s start_count: got %0d want %0d", name, starts - s0, hit ? 0 : 1);
    end
    bus.req = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
    @(negedge clk);
    vectors++;
    if (bus.resp !== 1'b0 || bus.rd_data !== 32'h0) begin
      miscompares++; $display("FAIL %s single_pulse: got resp=%b rd=%h want 0 0", name, bus.resp, bus.rd_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req = 1'b1; bus.funct3 = 3'b000; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
    bus.mul_resp = 1'b1; bus.mul_product = 64'd15;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.stall !== 1'b0 || bus.resp !== 1'b0 || bus.mul_start !== 1'b0 ||
          bus.rd_data !== 32'h0 || bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got stall=%b resp=%b start=%b rd=%h a=%h b=%h want all 0",
                 bus.stall, bus.resp, bus.mul_start, bus.rd_data, bus.mul_a, bus.mul_b);
      end
    end
    bus.req = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.mul_resp = 1'b0; bus.mul_product = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'd3, 32'd5, 1'b0, 32'd3, 32'd5, 64'd15, 2, 32'h0000_000F, "mul_3x5");
  endtask

  task automatic test_mulh_hit();
    // -3 x 5 shares magnitudes with the cached 3x5; product 15 negated, high half
    run_op(3'b001, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'd3, 32'd5, 64'd0, 0, 32'hFFFF_FFFF, "mulh_hit");
  endtask

  task automatic test_mulh();
    run_op(3'b001, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 32'd2, 64'd2, 1, 32'hFFFF_FFFF, "mulh_m1x2");
  endtask

  task automatic test_mulhu_cache();
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001, 3, 32'hFFFF_FFFE, "mulhu_max");
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'd0, 0, 32'h0000_0001, "mul_hit");
  endtask

  task automatic test_mulhsu_zero();
    run_op(3'b010, 32'h8000_0000, 32'd2, 1'b0, 32'h8000_0000, 32'd2,
           64'h0000_0001_0000_0000, 1, 32'hFFFF_FFFF, "mulhsu_min");
    run_op(3'b000, 32'd0, 32'd7, 1'b0, 32'd0, 32'd7, 64'd0, 2, 32'h0, "mul_zero");
  endtask

  task automatic test_ignored();
    @(negedge clk);
    bus.req = 1'b1; bus.funct3 = 3'b100; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++;
      if (bus.stall !== 1'b0 || bus.resp !== 1'b0 || bus.mul_start !== 1'b0) begin
        miscompares++;
        $display("FAIL ignored_f3_%0d: got stall=%b resp=%b start=%b want 0 0 0",
                 i, bus.stall, bus.resp, bus.mul_start);
      end
      @(negedge clk);
    end
    bus.req = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
  endtask

  task automatic test_stray_resp();
    @(negedge clk);
    bus.mul_resp = 1'b1; bus.mul_product = 64'd99;
    @(negedge clk);
    bus.mul_resp = 1'b0; bus.mul_product = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.resp !== 1'b0 || bus.stall !== 1'b0 || bus.mul_start !== 1'b0) begin
        miscompares++;
        $display("FAIL stray_resp: got resp=%b stall=%b start=%b want 0 0 0",
                 bus.resp, bus.stall, bus.mul_start);
      end
    end
  endtask

  task automatic test_abort();
    run_op(3'b000, 32'd3, 32'd5, 1'b0, 32'd3, 32'd5, 64'd15, 1, 32'h0000_000F, "mul_3x5_prime");
    @(negedge clk);
    bus.req = 1'b1; bus.funct3 = 3'b000; bus.rs1 = 32'd2; bus.rs2 = 32'd2;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    vectors++;
    if (bus.stall !== 1'b0 || bus.resp !== 1'b0 || bus.mul_start !== 1'b0 ||
        bus.rd_data !== 32'h0 || bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_outputs: got stall=%b resp=%b start=%b rd=%h a=%h b=%h want all 0",
               bus.stall, bus.resp, bus.mul_start, bus.rd_data, bus.mul_a, bus.mul_b);
    end
    bus.req = 1'b0; bus.rs1 = '0; bus.rs2 = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.mul_resp = 1'b1; bus.mul_product = 64'd4;
    @(negedge clk);
    bus.mul_resp = 1'b0; bus.mul_product = '0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.resp !== 1'b0 || bus.stall !== 1'b0) begin
        miscompares++; $display("FAIL late_resp: got resp=%b stall=%b want 0 0", bus.resp, bus.stall);
      end
    end
    run_op(3'b000, 32'd3, 32'd5, 1'b0, 32'd3, 32'd5, 64'd15, 1, 32'h0000_000F, "mul_after_reset");
  endtask

  initial begin
    bus.req = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.mul_resp = 1'b0; bus.mul_product = '0;
    test_reset();
    test_mul();
    test_mulh_hit();
    test_mulh();
    test_mulhu_cache();
    test_mulhsu_zero();
    test_ignored();
    test_stray_resp();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
